// File: rtl/ifm_pingpong_buffer_u3.sv
// ifm_pingpong_buffer_u3: ping/pong IFM store, three-unit write port, dual read ports A/B per unit.
module ifm_pingpong_buffer_u3 #(
    parameter int DATA_WIDTH       = 32,
    parameter int IFM_SIZE         = 32,
    parameter int NUMBER_OF_UNITS  = 3,
    parameter int ADDRESS_SIZE_IFM = $clog2(IFM_SIZE*IFM_SIZE)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        ifm_enable_write_current,
    input  logic [ADDRESS_SIZE_IFM-1:0] ifm_address_write_current,
    input  logic [DATA_WIDTH-1:0]       data_in_1,
    input  logic [DATA_WIDTH-1:0]       data_in_2,
    input  logic [DATA_WIDTH-1:0]       data_in_3,
    input  logic                        start_from_previous,
    output logic                        ready_to_previous,
    input  logic                        ifm_enable_read_A_next,
    input  logic                        ifm_enable_read_B_next,
    input  logic [ADDRESS_SIZE_IFM-1:0] ifm_address_read_A_next,
    input  logic [ADDRESS_SIZE_IFM-1:0] ifm_address_read_B_next,
    output logic [DATA_WIDTH-1:0]       data_out_A_unit1,
    output logic [DATA_WIDTH-1:0]       data_out_A_unit2,
    output logic [DATA_WIDTH-1:0]       data_out_A_unit3,
    output logic [DATA_WIDTH-1:0]       data_out_B_unit1,
    output logic [DATA_WIDTH-1:0]       data_out_B_unit2,
    output logic [DATA_WIDTH-1:0]       data_out_B_unit3,
    output logic                        start_to_next,
    input  logic                        end_from_next,
    output logic                        overflow_error
);
    localparam int DEPTH = IFM_SIZE*IFM_SIZE;

    logic [DATA_WIDTH-1:0] r_mem [NUMBER_OF_UNITS][2][DEPTH];
    logic [DATA_WIDTH-1:0] r_out_a [NUMBER_OF_UNITS];
    logic [DATA_WIDTH-1:0] r_out_b [NUMBER_OF_UNITS];
    logic [DATA_WIDTH-1:0] w_din [NUMBER_OF_UNITS];
    logic [1:0]            r_bank_full, w_full_nxt;
    logic                  r_wr_bank, r_rd_bank, r_rd_busy, r_start, r_ovf;
    logic                  w_ready, w_addr_ok, w_wr_ok, w_fill, w_rel, w_hand;

    assign w_din[0] = data_in_1;
    assign w_din[1] = data_in_2;
    assign w_din[2] = data_in_3;

    // A power-of-two depth makes every address legal; otherwise clip at the map size.
    if (DEPTH == 2**ADDRESS_SIZE_IFM) begin : g_full_range
        assign w_addr_ok = 1'b1;
    end else begin : g_clip_range
        assign w_addr_ok = ifm_address_write_current < ADDRESS_SIZE_IFM'(DEPTH);
    end

    assign w_ready = ~r_bank_full[r_wr_bank];
    assign w_wr_ok = ifm_enable_write_current & w_ready & w_addr_ok;
    assign w_fill  = start_from_previous & w_ready;
    assign w_rel   = end_from_next & r_rd_busy;
    assign w_hand  = ~r_rd_busy & r_bank_full[r_rd_bank];

    // Fill and release never hit the same bank: the write bank is empty, the read bank is full.
    always_comb begin
        w_full_nxt = r_bank_full;
        if (w_fill) w_full_nxt[r_wr_bank] = 1'b1;
        if (w_rel) w_full_nxt[r_rd_bank] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_bank_full <= '0;
            r_wr_bank   <= 1'b0;
            r_rd_bank   <= 1'b0;
            r_rd_busy   <= 1'b0;
            r_start     <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_bank_full <= w_full_nxt;
            r_wr_bank   <= r_wr_bank ^ w_fill;
            r_rd_bank   <= r_rd_bank ^ w_rel;
            r_rd_busy   <= w_hand | (r_rd_busy & ~w_rel);
            r_start     <= w_hand;
            r_ovf       <= r_ovf | (~w_ready & (ifm_enable_write_current | start_from_previous))
                                 | (end_from_next & ~r_rd_busy);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_ok)
            for (int k = 0; k < NUMBER_OF_UNITS; k++)
                r_mem[k][r_wr_bank][ifm_address_write_current] <= w_din[k];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NUMBER_OF_UNITS; k++) begin
                r_out_a[k] <= '0;
                r_out_b[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUMBER_OF_UNITS; k++) begin
                if (ifm_enable_read_A_next) r_out_a[k] <= r_mem[k][r_rd_bank][ifm_address_read_A_next];
                if (ifm_enable_read_B_next) r_out_b[k] <= r_mem[k][r_rd_bank][ifm_address_read_B_next];
            end
        end
    end

    assign ready_to_previous = w_ready;
    assign start_to_next     = r_start;
    assign overflow_error    = r_ovf;
    assign data_out_A_unit1  = r_out_a[0];
    assign data_out_A_unit2  = r_out_a[1];
    assign data_out_A_unit3  = r_out_a[2];
    assign data_out_B_unit1  = r_out_b[0];
    assign data_out_B_unit2  = r_out_b[1];
    assign data_out_B_unit3  = r_out_b[2];
endmodule

// File: tb/tb_ifm_pingpong_buffer_u3.sv
// tb_ifm_pingpong_buffer_u3: scenario tasks checking hand-off timing and bank contents
// against a word-level model of both banks.
module tb_ifm_pingpong_buffer_u3;
    logic        clk, reset, en_w, sfp, er_a, er_b, etn;
    logic [3:0]  aw, aa, ab;
    logic [31:0] din [3];
    logic [31:0] oa [3];
    logic [31:0] ob [3];
    logic        rdy, stn, ovf;
    logic [31:0] mm [2][3][16];
    int          n_cmp, n_bad;

    ifm_pingpong_buffer_u3 #(.DATA_WIDTH(32), .IFM_SIZE(4), .NUMBER_OF_UNITS(3)) dut (
        .clk(clk), .reset(reset),
        .ifm_enable_write_current(en_w), .ifm_address_write_current(aw),
        .data_in_1(din[0]), .data_in_2(din[1]), .data_in_3(din[2]),
        .start_from_previous(sfp), .ready_to_previous(rdy),
        .ifm_enable_read_A_next(er_a), .ifm_enable_read_B_next(er_b),
        .ifm_address_read_A_next(aa), .ifm_address_read_B_next(ab),
        .data_out_A_unit1(oa[0]), .data_out_A_unit2(oa[1]), .data_out_A_unit3(oa[2]),
        .data_out_B_unit1(ob[0]), .data_out_B_unit2(ob[1]), .data_out_B_unit3(ob[2]),
        .start_to_next(stn), .end_from_next(etn), .overflow_error(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int b, input int off, input bit rnd);
        for (int i = 0; i < 16; i++) begin
            en_w = 1'b1;
            aw = 4'(i);
            for (int k = 0; k < 3; k++) begin
                din[k] = rnd ? $urandom : 32'(100*(k+1) + i + off);
                mm[b][k][i] = din[k];
            end
            step;
        end
        en_w = 1'b0;
    endtask

    task automatic pulse_done;
        sfp = 1'b1;
        step;
        sfp = 1'b0;
    endtask

    task automatic pulse_end;
        etn = 1'b1;
        step;
        etn = 1'b0;
    endtask

    task automatic do_reset;
        reset = 1'b0;
        step;
        step;
        reset = 1'b1;
    endtask

    task automatic test_reset;
        #2;
        n_cmp++;
        if (oa[0] !== 32'd0 || ob[2] !== 32'd0 || rdy !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_async: oa0=%0h ob2=%0h rdy=%b want 0 0 1", oa[0], ob[2], rdy);
        end
        step;
        step;
        reset = 1'b1;
        repeat (5) step;
        n_cmp++;
        if (rdy !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", rdy); end
        n_cmp++;
        if (stn !== 1'b0) begin n_bad++; $display("FAIL reset_start: got %b want 0", stn); end
        n_cmp++;
        if (ovf !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %b want 0", ovf); end
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (oa[k] !== 32'd0 || ob[k] !== 32'd0) begin
                n_bad++;
                $display("FAIL reset_dout u%0d: A=%0h B=%0h want 0", k+1, oa[k], ob[k]);
            end
        end
    endtask

    task automatic test_single_frame;
        fill(0, 0, 1'b0);
        pulse_done;
        n_cmp++;
        if (stn !== 1'b0 || rdy !== 1'b1) begin
            n_bad++;
            $display("FAIL single_after_done: stn=%b rdy=%b want 0 1", stn, rdy);
        end
        step;
        n_cmp++;
        if (stn !== 1'b1) begin n_bad++; $display("FAIL single_start: got %b want 1", stn); end
        step;
        n_cmp++;
        if (stn !== 1'b0) begin n_bad++; $display("FAIL single_start_width: got %b want 0", stn); end
        er_a = 1'b1; aa = 4'd3; er_b = 1'b1; ab = 4'd12;
        step;
        er_a = 1'b0; er_b = 1'b0;
        n_cmp++;
        if (oa[1] !== 32'd203) begin n_bad++; $display("FAIL single_A_u2: got %0d want 203", oa[1]); end
        n_cmp++;
        if (ob[2] !== 32'd312) begin n_bad++; $display("FAIL single_B_u3: got %0d want 312", ob[2]); end
        aa = 4'd7; ab = 4'd9;
        step;
        n_cmp++;
        if (oa[0] !== 32'd103 || ob[0] !== 32'd112) begin
            n_bad++;
            $display("FAIL single_hold: A=%0d B=%0d want 103 112", oa[0], ob[0]);
        end
        pulse_end;
        n_cmp++;
        if (ovf !== 1'b0 || rdy !== 1'b1) begin
            n_bad++;
            $display("FAIL single_release: ovf=%b rdy=%b want 0 1", ovf, rdy);
        end
    endtask

    task automatic test_pingpong;
        fill(1, 0, 1'b1);
        pulse_done;
        step;
        n_cmp++;
        if (stn !== 1'b1) begin n_bad++; $display("FAIL pp_start1: got %b want 1", stn); end
        for (int i = 0; i < 16; i++) begin
            en_w = 1'b1;
            aw = 4'(i);
            for (int k = 0; k < 3; k++) begin
                din[k] = 32'(100*(k+1) + i + 1000);
                mm[0][k][i] = din[k];
            end
            er_a = 1'b1; aa = 4'($urandom_range(0, 15));
            er_b = 1'b1; ab = 4'($urandom_range(0, 15));
            step;
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (oa[k] !== mm[1][k][aa] || ob[k] !== mm[1][k][ab]) begin
                    n_bad++;
                    $display("FAIL pp_overlap_read u%0d: A=%0h B=%0h want %0h %0h",
                             k+1, oa[k], ob[k], mm[1][k][aa], mm[1][k][ab]);
                end
            end
        end
        en_w = 1'b0; er_a = 1'b0; er_b = 1'b0;
        pulse_done;
        n_cmp++;
        if (rdy !== 1'b0) begin n_bad++; $display("FAIL pp_both_full_ready: got %b want 0", rdy); end
        step;
        n_cmp++;
        if (stn !== 1'b0) begin n_bad++; $display("FAIL pp_no_start_busy: got %b want 0", stn); end
        pulse_end;
        n_cmp++;
        if (stn !== 1'b0 || rdy !== 1'b1) begin
            n_bad++;
            $display("FAIL pp_after_end: stn=%b rdy=%b want 0 1", stn, rdy);
        end
        step;
        n_cmp++;
        if (stn !== 1'b1) begin n_bad++; $display("FAIL pp_start2: got %b want 1", stn); end
        er_a = 1'b1; aa = 4'd0;
        step;
        er_a = 1'b0;
        n_cmp++;
        if (oa[0] !== 32'd1100) begin n_bad++; $display("FAIL pp_read_1100: got %0d want 1100", oa[0]); end
    endtask

    task automatic test_simultaneous;
        fill(1, 0, 1'b1);
        sfp = 1'b1; etn = 1'b1;
        step;
        sfp = 1'b0; etn = 1'b0;
        n_cmp++;
        if (rdy !== 1'b1 || stn !== 1'b0 || ovf !== 1'b0) begin
            n_bad++;
            $display("FAIL simul_edge: rdy=%b stn=%b ovf=%b want 1 0 0", rdy, stn, ovf);
        end
        step;
        n_cmp++;
        if (stn !== 1'b1) begin n_bad++; $display("FAIL simul_start: got %b want 1", stn); end
        for (int n = 0; n < 6; n++) begin
            er_a = 1'b1; aa = 4'($urandom_range(0, 15));
            er_b = 1'b1; ab = aa;
            step;
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (oa[k] !== mm[1][k][aa] || ob[k] !== mm[1][k][aa]) begin
                    n_bad++;
                    $display("FAIL simul_read u%0d: A=%0h B=%0h want %0h", k+1, oa[k], ob[k], mm[1][k][aa]);
                end
            end
        end
        er_a = 1'b0; er_b = 1'b0;
    endtask

    task automatic test_violation;
        fill(0, 0, 1'b1);
        pulse_done;
        n_cmp++;
        if (rdy !== 1'b0 || ovf !== 1'b0) begin
            n_bad++;
            $display("FAIL viol_full: rdy=%b ovf=%b want 0 0", rdy, ovf);
        end
        en_w = 1'b1; aw = 4'd5;
        for (int k = 0; k < 3; k++) din[k] = 32'hDEAD;
        step;
        en_w = 1'b0;
        n_cmp++;
        if (ovf !== 1'b1) begin n_bad++; $display("FAIL viol_write_flag: got %b want 1", ovf); end
        pulse_end;
        n_cmp++;
        if (rdy !== 1'b1) begin n_bad++; $display("FAIL viol_ready_back: got %b want 1", rdy); end
        step;
        n_cmp++;
        if (stn !== 1'b1) begin n_bad++; $display("FAIL viol_start: got %b want 1", stn); end
        er_a = 1'b1; aa = 4'd5;
        step;
        er_a = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (oa[k] !== mm[0][k][5]) begin
                n_bad++;
                $display("FAIL viol_unchanged u%0d: got %0h want %0h", k+1, oa[k], mm[0][k][5]);
            end
        end
        pulse_end;
        do_reset;
        n_cmp++;
        if (ovf !== 1'b0) begin n_bad++; $display("FAIL viol_reset_clear: got %b want 0", ovf); end
        pulse_end;
        n_cmp++;
        if (ovf !== 1'b1) begin n_bad++; $display("FAIL viol_stray_end: got %b want 1", ovf); end
        do_reset;
    endtask

    task automatic test_reset_mid;
        fill(0, 0, 1'b1);
        pulse_done;
        step;
        n_cmp++;
        if (stn !== 1'b1) begin n_bad++; $display("FAIL rmid_start: got %b want 1", stn); end
        er_a = 1'b1; aa = 4'd1; er_b = 1'b1; ab = 4'd2;
        step;
        er_a = 1'b0; er_b = 1'b0;
        fill(1, 0, 1'b1);
        pulse_done;
        n_cmp++;
        if (rdy !== 1'b0) begin n_bad++; $display("FAIL rmid_full: got %b want 0", rdy); end
        #3;
        reset = 1'b0;
        #1;
        n_cmp++;
        if (rdy !== 1'b1 || stn !== 1'b0 || ovf !== 1'b0) begin
            n_bad++;
            $display("FAIL rmid_async_flags: rdy=%b stn=%b ovf=%b want 1 0 0", rdy, stn, ovf);
        end
        n_cmp++;
        if (oa[0] !== 32'd0 || ob[1] !== 32'd0) begin
            n_bad++;
            $display("FAIL rmid_async_dout: A=%0h B=%0h want 0", oa[0], ob[1]);
        end
        step;
        step;
        reset = 1'b1;
        for (int n = 0; n < 6; n++) begin
            step;
            n_cmp++;
            if (stn !== 1'b0 || rdy !== 1'b1) begin
                n_bad++;
                $display("FAIL rmid_after_release c%0d: stn=%b rdy=%b want 0 1", n, stn, rdy);
            end
        end
    endtask

    task automatic test_random_frames;
        for (int f = 0; f < 3; f++) begin
            int b = f % 2;
            int t = 0;
            fill(b, 0, 1'b1);
            pulse_done;
            while (stn !== 1'b1 && t < 8) begin
                step;
                t++;
            end
            n_cmp++;
            if (stn !== 1'b1 || t != 1) begin
                n_bad++;
                $display("FAIL rand_start f%0d: stn=%b after %0d cycles want 1 after 1", f, stn, t);
            end
            for (int n = 0; n < 8; n++) begin
                er_a = 1'($urandom_range(0, 1)); aa = 4'($urandom_range(0, 15));
                er_b = 1'b1; ab = 4'($urandom_range(0, 15));
                step;
                for (int k = 0; k < 3; k++) begin
                    n_cmp++;
                    if (ob[k] !== mm[b][k][ab] || (er_a && oa[k] !== mm[b][k][aa])) begin
                        n_bad++;
                        $display("FAIL rand_read f%0d u%0d: A=%0h B=%0h want %0h %0h",
                                 f, k+1, oa[k], ob[k], mm[b][k][aa], mm[b][k][ab]);
                    end
                end
            end
            er_a = 1'b0; er_b = 1'b0;
            pulse_end;
        end
        n_cmp++;
        if (ovf !== 1'b0) begin n_bad++; $display("FAIL rand_ovf: got %b want 0", ovf); end
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        reset = 1'b0; en_w = 1'b0; sfp = 1'b0; er_a = 1'b0; er_b = 1'b0; etn = 1'b0;
        aw = '0; aa = '0; ab = '0;
        for (int k = 0; k < 3; k++) din[k] = '0;
        test_reset;
        test_single_frame;
        test_pingpong;
        test_simultaneous;
        test_violation;
        test_reset_mid;
        test_random_frames;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ifm_pingpong_buffer_u3.md
# ifm_pingpong_buffer_U3

Double-buffered (ping/pong) IFM store sitting between a producing layer (conv, three units wide) and a consuming pool layer with dual read ports A/B. The producer writes one feature map per unit into the write bank and pulses done. The buffer then hands the full bank to the consumer via `start_to_next` and frees it on `end_from_next`. The producer can fill the other bank while the consumer reads.

## Interface
- `DATA_WIDTH`, 32, word width.
- `IFM_SIZE`, 32, feature-map side; each bank stores IFM_SIZE*IFM_SIZE words per unit.
- `NUMBER_OF_UNITS`, 3, fixed; the ports are per unit.
- `ADDRESS_SIZE_IFM`, $clog2(IFM_SIZE*IFM_SIZE), address width.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `ifm_enable_write_current` in 1: write strobe from producer.
- `ifm_address_write_current` in ADDRESS_SIZE_IFM: write address.
- `data_in_1`, `data_in_2`, `data_in_3` in DATA_WIDTH: per-unit write data.
- `start_from_previous` in 1: one-cycle pulse; current write bank is complete.
- `ready_to_previous` out 1: write bank is empty, so the producer may write.
- `ifm_enable_read_A_next`, `ifm_enable_read_B_next` in 1: read strobes.
- `ifm_address_read_A_next`, `ifm_address_read_B_next` in ADDRESS_SIZE_IFM: read addresses.
- `data_out_A_unit1..3`, `data_out_B_unit1..3` out DATA_WIDTH: registered read data.
- `start_to_next` out 1: one-cycle pulse; read bank is full and handed to consumer.
- `end_from_next` in 1: one-cycle pulse; consumer finished with read bank.
- `overflow_error` out 1: sticky protocol-violation flag.

## Operation
- State registers:
  - `bank_full[1:0]`
  - `wr_bank` (1 bit)
  - `rd_bank` (1 bit)
  - `rd_busy`
- Memory: 2 banks × 3 units × IFM_SIZE² words.
  - One write port.
  - Two read ports (A, B) per unit.
- Write:
  - When the enable is sampled high, `ready_to_previous` = 1 and the address is < IFM_SIZE², store `data_in_k` into bank `wr_bank`, unit k, at that address.
  - Otherwise no write occurs.
- `ready_to_previous` = ~`bank_full[wr_bank]`. It is decoded from registers only (no input path).
- Fill complete: `start_from_previous` sampled with `ready_to_previous` = 1 sets `bank_full[wr_bank]` = 1 and toggles `wr_bank`.
- Hand-off:
  - At any edge where `rd_busy` = 0 and `bank_full[rd_bank]` = 1, register `start_to_next` = 1 for exactly one cycle and set `rd_busy` = 1.
- Release:
  - `end_from_next` sampled with `rd_busy` = 1 clears `bank_full[rd_bank]`, toggles `rd_bank` and clears `rd_busy`.
  - `end_from_next` with `rd_busy` = 0 is ignored and sets `overflow_error`.
- Read: `data_out_X_unitk` ← bank `rd_bank`, unit k, at `ifm_address_read_X_next`, registered when `ifm_enable_read_X_next` = 1.
  - Output holds its value while the enable is low.
  - A and B are independent; the same address on both returns the same word.
- Per-bank state, encoded by the full flag plus the rd pointer/busy: EMPTY → (done pulse) FULL → (start_to_next) READING → (end_from_next) EMPTY.
- `overflow_error` sets on either of:
  - a write strobe or `start_from_previous` while `ready_to_previous` = 0;
  - a stray `end_from_next`.
  - It clears only on reset.

## Timing
- Reset asserted: the following take the values listed, immediately and asynchronously.
  - `bank_full` = 00
  - `wr_bank` = `rd_bank` = 0
  - `rd_busy` = 0
  - `start_to_next` = 0
  - `overflow_error` = 0
  - all `data_out` = 0
  - `ready_to_previous` = 1
- Memory contents are not cleared.
- Reset mid-operation abandons both banks; no `start_to_next` follows.
- Read latency: 1 cycle. Enable and address are sampled at edge N; data is valid after edge N. Back-to-back reads are supported every cycle.
- Fill-to-start: `start_from_previous` sampled at edge N → `bank_full` set after N → `start_to_next` high after N+1, for one cycle.
- Release-to-next-start: `end_from_next` at edge N; if the other bank is already full, `start_to_next` is high after N+1.
- Write-to-read: a word written at edge N is readable by a read sampled at edge N+2 or later, once its bank is handed off.
- Simultaneous events:
  - `start_from_previous` and `end_from_next` in the same cycle both take effect; they always target different banks.
  - Fill of the last empty bank → `ready_to_previous` drops after that edge.
  - A release in the same cycle as a fill while both banks would be full → `ready_to_previous` stays/returns 1 after the edge.
- Both banks full: `ready_to_previous` = 0 until the next `end_from_next`. `ready_to_previous` = 1 the cycle after the release edge.

## Test plan
Bench uses IFM_SIZE = 4 (16 words, 4-bit address).
- **Reset values:** release reset, idle 5 cycles → `ready_to_previous` = 1, `start_to_next` = 0, `data_out` = 0, `overflow_error` = 0.
- **Single frame:**
  - Stimulus: write addr i with data_in_k = 100*k + i (i = 0..15), then pulse `start_from_previous`.
  - Expected: `start_to_next` pulses exactly 2 cycles after the pulse.
  - Then read A at addr 3 and B at addr 12 in the same cycle → next cycle A_unit2 = 203, B_unit3 = 312.
- **Ping-pong overlap:**
  - Stimulus: fill bank 0, and while the consumer reads it, fill bank 1 with data + 1000.
  - Expected: `ready_to_previous` = 0 after the second done.
  - Then `end_from_next` → `start_to_next` 2 cycles later, and a read at addr 0 returns 1100 on unit1.
- **Simultaneous done/end:**
  - Stimulus: bank 0 READING, bank 1 being written; pulse `start_from_previous` and `end_from_next` in the same cycle.
  - Expected: `start_to_next` next-next cycle for bank 1; `ready_to_previous` = 1; no `overflow_error`.
- **Protocol violation:**
  - Stimulus: with both banks full, issue a write to addr 5 with data 0xDEAD.
  - Expected: `overflow_error` = 1; bank contents unchanged at addr 5 when later read.
  - A stray `end_from_next` while idle also sets the flag.
- **Reset mid-read:**
  - Stimulus: assert reset while `rd_busy` = 1 and the other bank is full.
  - Expected: all flags cleared asynchronously; no `start_to_next` after release; `ready_to_previous` = 1.
